alu_sequencer: RTL and testbench

Multi-cycle execute controller that drives the 16-bit one-hot-opcode ALU and consumes its 17-bit result. It accepts one instruction at a time over a valid/ready handshake and reads operands from the register file. It then drives the ALU op lines and operands, captures the result and updates C/Z/N flags. Finally it performs register writeback, a memory access (LD/ST) or a dump-port push (LDUMP/SDUMP). It sits between fetch and the register file, ALU and data-memory port.

---
 rtl/alu_seq_pkg.sv | 52 +++++
 rtl/alu_sequencer_if.sv | 49 ++++
 rtl/mem_timeout_ctr.sv | 25 ++
 rtl/alu_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU execute sequencer: opcodes, FSM states,
// instruction field positions, opcode -> one-hot ALU select and flag enable.
// No logic of its own; imported by the sequencer and its interface users.
package alu_seq_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_CMP   = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOT   = 5'd7,
    OP_NEG   = 5'd8,
    OP_SHL   = 5'd9,
    OP_SHR   = 5'd10,
    OP_ST    = 5'd11,
    OP_LD    = 5'd12,
    OP_MOV   = 5'd13,
    OP_LDUMP = 5'd14,
    OP_SDUMP = 5'd15
  } opcode_t;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_EXEC = 3'd1;
  localparam state_t S_MEM  = 3'd2;
  localparam state_t S_DUMP = 3'd3;
  localparam state_t S_WB   = 3'd4;

  // Instruction word: [15:11] opcode, [10:8] rd, [7:5] rs, [4] use_imm, [3:0] imm
  localparam int OPC_LSB     = 11;
  localparam int RD_LSB      = 8;
  localparam int RS_LSB      = 5;
  localparam int USE_IMM_BIT = 4;
  localparam int IMM_LSB     = 0;

  // Opcode n (1..15) selects ALU op line n-1; NOP and illegal codes select nothing.
  function automatic logic [14:0] op_onehot(input logic [4:0] opc);
    logic [14:0] oh;
    oh = '0;
    if (opc != 5'd0 && !opc[4]) oh = 15'd1 << (opc - 5'd1);
    return oh;
  endfunction

  // Only the arithmetic/logic/shift group (ADD..SHR) updates C/Z/N.
  function automatic logic op_sets_flags(input logic [4:0] opc);
    return (opc >= 5'd1) && (opc <= 5'd10);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of all non-clock signals around the sequencer: fetch handshake,
// register file ports, ALU ports, data memory port, dump port, status.
// master = sequencer side, slave = surrounding datapath / environment.
interface alu_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [2:0]        rf_raddr_a;
  logic [2:0]        rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [14:0]       alu_op;
  logic [DATA_W-1:0] alu_r1;
  logic [DATA_W-1:0] alu_r2;
  logic [DATA_W:0]   alu_result;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [2:0]        flags;
  logic              illegal_op;
  logic              bus_err;

  modport master (
    input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_result,
           mem_ack, mem_rdata, dump_ready,
    output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
           alu_op, alu_r1, alu_r2, mem_req, mem_we, mem_addr, mem_wdata,
           dump_valid, dump_data, flags, illegal_op, bus_err
  );

  modport slave (
    output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_result,
           mem_ack, mem_rdata, dump_ready,
    input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
           alu_op, alu_r1, alu_r2, mem_req, mem_we, mem_addr, mem_wdata,
           dump_valid, dump_data, flags, illegal_op, bus_err
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts memory wait cycles; expire fires on the MAX-th enabled cycle.
// Latency: expire is combinational from count and en; load clears next edge.
// Ports: clk, rst (async high), load (clear), en (count), expire (out).
module mem_timeout_ctr #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  // cnt holds the number of earlier ack-less cycles, so MAX-1 marks the last one.
  assign expire = en && (cnt == W'(MAX - 1));
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller: fetch handshake -> ALU -> mem/dump -> writeback.
// Latency: ALU op accepted at edge 0, EXEC cycle 1, WB cycle 2, ready in cycle 3.
// Backpressure: instr_ready only in IDLE; MEM waits on mem_ack (bounded), DUMP on dump_ready.
// Ports: clk, rst (async high), bus (alu_sequencer_if.master: all handshake/bus signals).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.master bus
);

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W:0]   res;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] ld_q;
  logic [2:0]        flags_q;
  logic              ill_q;
  logic              berr_q;

  logic [4:0]        opc;
  logic [4:0]        new_opc;
  logic [DATA_W-1:0] imm_ext;
  logic              use_imm;
  logic              is_mem;
  logic              is_dump;
  logic              tmo_expire;

  assign opc     = ir[OPC_LSB +: 5];
  assign new_opc = bus.instr[OPC_LSB +: 5];
  assign use_imm = ir[USE_IMM_BIT];
  assign imm_ext = {{(DATA_W-4){1'b0}}, ir[IMM_LSB +: 4]};
  assign is_mem  = (opc == OP_LD)    || (opc == OP_ST);
  assign is_dump = (opc == OP_LDUMP) || (opc == OP_SDUMP);

  mem_timeout_ctr #(.MAX(MEM_TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (state == S_EXEC),
    .en     ((state == S_MEM) && !bus.mem_ack),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ir      <= '0;
      res     <= '0;
      opa_q   <= '0;
      ld_q    <= '0;
      flags_q <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      ill_q  <= 1'b0;
      berr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            ir <= bus.instr;
            if (new_opc[4])            ill_q <= 1'b1;
            else if (new_opc != OP_NOP) state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res   <= bus.alu_result;
          // rd value is kept for the store data phase, which is after the ALU cycle.
          opa_q <= bus.rf_rdata_a;
          if (is_mem)       state <= S_MEM;
          else if (is_dump) state <= S_DUMP;
          else              state <= S_WB;
        end
        S_MEM: begin
          // An ack on the last allowed cycle still completes the access.
          if (bus.mem_ack) begin
            if (opc == OP_LD) begin
              ld_q  <= bus.mem_rdata;
              state <= S_WB;
            end else begin
              state <= S_IDLE;
            end
          end else if (tmo_expire) begin
            berr_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_DUMP: begin
          if (bus.dump_ready) state <= (opc == OP_SDUMP) ? S_IDLE : S_WB;
        end
        S_WB: begin
          if (op_sets_flags(opc))
            flags_q <= {res[DATA_W], ~|res[DATA_W-1:0], res[DATA_W-1]};
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.rf_raddr_a  = ir[RD_LSB +: 3];
  assign bus.rf_raddr_b  = ir[RS_LSB +: 3];

  assign bus.alu_op = (state == S_EXEC) ? op_onehot(opc) : '0;
  // Loads/stores form the address from rs + imm regardless of use_imm.
  assign bus.alu_r1 = (state != S_EXEC) ? '0 :
                      is_mem ? bus.rf_rdata_b : bus.rf_rdata_a;
  assign bus.alu_r2 = (state != S_EXEC) ? '0 :
                      (is_mem || use_imm) ? imm_ext : bus.rf_rdata_b;

  assign bus.mem_req   = (state == S_MEM);
  assign bus.mem_we    = (state == S_MEM) && (opc == OP_ST);
  assign bus.mem_addr  = (state == S_MEM) ? res[DATA_W-1:0] : '0;
  assign bus.mem_wdata = (state == S_MEM) ? opa_q : '0;

  assign bus.dump_valid = (state == S_DUMP);
  assign bus.dump_data  = (state == S_DUMP) ? res[DATA_W-1:0] : '0;

  assign bus.rf_we    = (state == S_WB) && (opc != OP_CMP);
  assign bus.rf_waddr = bus.rf_we ? ir[RD_LSB +: 3] : '0;
  assign bus.rf_wdata = !bus.rf_we ? '0 :
                        (opc == OP_LD) ? ld_q : res[DATA_W-1:0];

  assign bus.flags      = flags_q;
  assign bus.illegal_op = ill_q;
  assign bus.bus_err    = berr_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: environment register file, ALU and
// memory/dump responders, an instruction-level reference model that predicts
// every cycle's outputs, and one compare process sampling on the falling edge.
module tb_alu_sequencer;

  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_W(16)) bus ();

  alu_sequencer #(.DATA_W(16), .MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- environment: register file and ALU ----------------
  logic [15:0] rf [8];
  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];
  always @(posedge clk) if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;

  function automatic logic [16:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      5'd1:        return {1'b0, a} + {1'b0, b};
      5'd2, 5'd3:  return {1'b0, a} - {1'b0, b};
      5'd4:        return {1'b0, a & b};
      5'd5:        return {1'b0, a | b};
      5'd6:        return {1'b0, a ^ b};
      5'd7:        return {1'b0, ~a};
      5'd8:        return 17'd0 - {1'b0, a};
      5'd9:        return {a, 1'b0};
      5'd10:       return {a[0], 1'b0, a[15:1]};
      5'd11, 5'd12: return {1'b0, a} + {1'b0, b};
      5'd13:       return {1'b0, b};
      5'd14, 5'd15: return {1'b0, a};
      default:     return 17'd0;
    endcase
  endfunction

  always_comb begin : alu_env
    logic [4:0] opn;
    opn = 5'd0;
    for (int i = 0; i < 15; i++) if (bus.alu_op[i]) opn = 5'(i + 1);
    bus.alu_result = alu_fn(opn, bus.alu_r1, bus.alu_r2);
  end

  // ---------------- observation counters for literal pins ----------------
  int          req_cnt = 0;
  int          ill_cnt = 0;
  int          berr_cnt = 0;
  logic [15:0] last_maddr = '0;
  logic [15:0] last_dd = '0;
  logic [14:0] last_op = '0;
  always @(negedge clk) begin
    if (bus.mem_req) begin req_cnt++; last_maddr = bus.mem_addr; end
    if (bus.dump_valid) last_dd = bus.dump_data;
    if (bus.alu_op != '0) last_op = bus.alu_op;
    if (bus.illegal_op) ill_cnt++;
    if (bus.bus_err) berr_cnt++;
  end

  // ---------------- reference model state and expectations ----------------
  logic [15:0] mrf [8];
  logic [2:0]  mflags = '0;
  logic [15:0] last_instr = '0;
  logic        pend_ill = 1'b0, pend_berr = 1'b0;

  logic        e_on = 1'b0;
  logic        e_ready, e_we, e_req, e_mwe, e_dv, e_ill, e_berr;
  logic [2:0]  e_ra, e_rb, e_waddr, e_flags;
  logic [15:0] e_wdata, e_r1, e_r2, e_maddr, e_mwdata, e_dd;
  logic [14:0] e_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Idle-cycle expectations; non-idle steps override what they change.
  task automatic defaults();
    e_ready = 1'b1; e_we = 1'b0; e_waddr = '0; e_wdata = '0;
    e_op = '0; e_r1 = '0; e_r2 = '0;
    e_req = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwdata = '0;
    e_dv = 1'b0; e_dd = '0;
    e_ill = pend_ill; e_berr = pend_berr; pend_ill = 1'b0; pend_berr = 1'b0;
    e_ra = last_instr[10:8]; e_rb = last_instr[7:5]; e_flags = mflags;
    bus.instr_valid = 1'b0; bus.instr = 16'($urandom);
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'($urandom); bus.dump_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    defaults();
  endtask

  task automatic set_reg(input int i, input logic [15:0] v);
    rf[i] <= v;
    mrf[i] = v;
  endtask

  always @(negedge clk) begin
    if (e_on) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(e_ready));
      chk("rf_raddr_a", 32'(bus.rf_raddr_a), 32'(e_ra));
      chk("rf_raddr_b", 32'(bus.rf_raddr_b), 32'(e_rb));
      chk("rf_we", 32'(bus.rf_we), 32'(e_we));
      if (e_we) begin
        chk("rf_waddr", 32'(bus.rf_waddr), 32'(e_waddr));
        chk("rf_wdata", 32'(bus.rf_wdata), 32'(e_wdata));
      end
      chk("alu_op", 32'(bus.alu_op), 32'(e_op));
      if (e_op != '0) begin
        chk("alu_r1", 32'(bus.alu_r1), 32'(e_r1));
        chk("alu_r2", 32'(bus.alu_r2), 32'(e_r2));
      end
      chk("mem_req", 32'(bus.mem_req), 32'(e_req));
      if (e_req) begin
        chk("mem_we", 32'(bus.mem_we), 32'(e_mwe));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_maddr));
        if (e_mwe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_mwdata));
      end
      chk("dump_valid", 32'(bus.dump_valid), 32'(e_dv));
      if (e_dv) chk("dump_data", 32'(bus.dump_data), 32'(e_dd));
      chk("flags", 32'(bus.flags), 32'(e_flags));
      chk("illegal_op", 32'(bus.illegal_op), 32'(e_ill));
      chk("bus_err", 32'(bus.bus_err), 32'(e_berr));
    end
  end

  // Issue one instruction and predict each cycle until the sequencer is idle again.
  // lat: MEM cycle carrying mem_ack (0 = never); dly: dump_ready low cycles;
  // abort_at: return during that MEM cycle without finishing (0 = never).
  task automatic run_instr(input logic [15:0] w, input int lat, input int dly,
                           input logic [15:0] rdv, input int abort_at);
    logic [4:0]  op;
    logic [2:0]  rd, rs;
    logic [15:0] a, b, r1, r2, wd;
    logic [16:0] res;
    logic        acked;
    op = w[15:11]; rd = w[10:8]; rs = w[7:5];
    next_cycle();
    bus.instr_valid = 1'b1; bus.instr = w;
    last_instr = w;
    if (op == 5'd0) return;
    if (op >= 5'd16) begin pend_ill = 1'b1; return; end
    a = mrf[rd]; b = mrf[rs];
    if (op == 5'd11 || op == 5'd12) begin
      r1 = b; r2 = {12'd0, w[3:0]};
    end else begin
      r1 = a; r2 = w[4] ? {12'd0, w[3:0]} : b;
    end
    res = alu_fn(op, r1, r2);
    wd  = res[15:0];
    next_cycle();
    e_ready = 1'b0; e_op = 15'd1 << (op - 5'd1); e_r1 = r1; e_r2 = r2;
    if (op == 5'd11 || op == 5'd12) begin
      acked = 1'b0;
      for (int k = 1; k <= TO && !acked; k++) begin
        next_cycle();
        e_ready = 1'b0; e_req = 1'b1; e_mwe = (op == 5'd11);
        e_maddr = res[15:0]; e_mwdata = a;
        if (k == abort_at) return;
        if (k == lat) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdv; acked = 1'b1; end
      end
      if (!acked) begin pend_berr = 1'b1; return; end
      if (op == 5'd11) return;
      wd = rdv;
    end else if (op >= 5'd14) begin
      for (int k = 0; k <= dly; k++) begin
        next_cycle();
        e_ready = 1'b0; e_dv = 1'b1; e_dd = res[15:0];
        if (k == dly) bus.dump_ready = 1'b1;
      end
      if (op == 5'd15) return;
    end
    next_cycle();
    e_ready = 1'b0;
    if (op != 5'd3) begin e_we = 1'b1; e_waddr = rd; e_wdata = wd; mrf[rd] = wd; end
    if (op <= 5'd10) mflags = {res[16], res[15:0] == 16'd0, res[15]};
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_instr_ready"}, 32'(bus.instr_ready), 32'd1);
    chk({tag, "_raddr"}, 32'({bus.rf_raddr_a, bus.rf_raddr_b}), 32'd0);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, "_rf_wdata"}, 32'(bus.rf_wdata), 32'd0);
    chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
    chk({tag, "_alu_r"}, {bus.alu_r1, bus.alu_r2}, 32'd0);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_dump_valid"}, 32'(bus.dump_valid), 32'd0);
    chk({tag, "_flags"}, 32'(bus.flags), 32'd0);
    chk({tag, "_pulses"}, 32'({bus.illegal_op, bus.bus_err}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.instr = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.dump_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_reg(i, 16'($urandom));
    #3;
    check_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    defaults();
    e_on = 1'b1;

    // ADD r1 += r2 with 0xFFFF + 1
    set_reg(1, 16'hFFFF); set_reg(2, 16'h0001);
    run_instr({5'd1, 3'd1, 3'd2, 1'b0, 4'd0}, 0, 0, 16'h0, 0);
    next_cycle();
    chk("lit_add_wdata", 32'(rf[1]), 32'h0000);
    chk("lit_add_flags", 32'(bus.flags), 32'b110);

    // CMP r3 with imm 7
    set_reg(3, 16'h0005);
    run_instr({5'd3, 3'd3, 3'd0, 1'b1, 4'd7}, 0, 0, 16'h0, 0);
    next_cycle();
    chk("lit_cmp_flags", 32'(bus.flags), 32'b101);
    chk("lit_cmp_alu_op", 32'(last_op), 32'h0004);
    chk("lit_cmp_no_wb", 32'(rf[3]), 32'h0005);

    // LD r2 <- mem[r4 + 3], ack in 4th MEM cycle
    set_reg(4, 16'h0100);
    run_instr({5'd12, 3'd2, 3'd4, 1'b0, 4'd3}, 4, 0, 16'hBEEF, 0);
    next_cycle();
    chk("lit_ld_addr", 32'(last_maddr), 32'h0103);
    chk("lit_ld_wdata", 32'(rf[2]), 32'hBEEF);
    chk("lit_ld_flags", 32'(bus.flags), 32'b101);

    // ST with no ack: timeout
    req_cnt = 0; berr_cnt = 0;
    run_instr({5'd11, 3'd1, 3'd2, 1'b0, 4'd0}, 0, 0, 16'h0, 0);
    next_cycle();
    next_cycle();
    chk("lit_st_req_cycles", 32'(req_cnt), 32'(TO));
    chk("lit_st_bus_err", 32'(berr_cnt), 32'd1);

    // SDUMP / LDUMP with dump_ready held low
    set_reg(5, 16'h1234);
    run_instr({5'd15, 3'd5, 3'd0, 1'b0, 4'd0}, 0, 3, 16'h0, 0);
    next_cycle();
    chk("lit_sdump_data", 32'(last_dd), 32'h1234);
    set_reg(6, 16'h00A5);
    run_instr({5'd14, 3'd6, 3'd1, 1'b0, 4'd0}, 0, 2, 16'h0, 0);
    next_cycle();
    chk("lit_ldump_data", 32'(last_dd), 32'h00A5);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[15:11] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31))
                                             : 5'($urandom_range(0, 15));
      run_instr(w, $urandom_range(1, 6), $urandom_range(0, 3), 16'($urandom), 0);
    end

    // illegal opcode, then reset in the middle of a load's MEM phase
    next_cycle();
    next_cycle();
    ill_cnt = 0;
    run_instr({5'd20, 11'd0}, 0, 0, 16'h0, 0);
    run_instr({5'd12, 3'd2, 3'd4, 1'b0, 4'd3}, 0, 0, 16'h0, 3);
    #1;
    chk("lit_illegal_pulses", 32'(ill_cnt), 32'd1);
    chk("pre_reset_mem_req", 32'(bus.mem_req), 32'd1);
    #1;
    e_on = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("midop_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mflags = '0; last_instr = '0; pend_ill = 1'b0; pend_berr = 1'b0;
    defaults();
    e_on = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[15:11] = 5'($urandom_range(0, 15));
      run_instr(w, $urandom_range(1, 6), $urandom_range(0, 3), 16'($urandom), 0);
    end
    next_cycle();
    next_cycle();
    e_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
